ga23_sdr_arbiter: RTL and testbench
===================================

GA23_SDR_ARBITER -- requirements
Module: ga23_sdr_arbiter

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3: number of tile-layer requesters (2..4).
REQ-002 SHALL have parameter ADDR_W, default 22: SDRAM word address width.
REQ-003 SHALL have parameter DATA_W, default 32: tile row data width.
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port layer_req  in  NUM_LAYERS: per-layer one-cycle request pulse.
REQ-007 SHALL have port layer_addr  in  NUM_LAYERS*ADDR_W: per-layer address, valid with layer_req; layer i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port layer_data  out  NUM_LAYERS*DATA_W: per-layer returned row, held until that layer's next completion.
REQ-009 SHALL have port layer_rdy  out  NUM_LAYERS: one-cycle pulse, layer_data for that layer is new.
REQ-010 SHALL have port mem_req  out  1: level request to SDRAM channel.
REQ-011 SHALL have port mem_addr  out  ADDR_W: address, stable while mem_req=1.
REQ-012 SHALL have port mem_ack  in  1: one-cycle pulse, mem_data valid this cycle.
REQ-013 SHALL have port mem_data  in  DATA_W: SDRAM read data.
REQ-014 SHALL have port busy  out  1: high in any state other than IDLE.

Function
REQ-015 SHALL keep one pending bit and one address register per layer; layer_req sets the bit and captures layer_addr on the same edge.
REQ-016 SHALL, when a layer_req arrives while that layer is already pending and not yet granted, overwrite the stored address (latest wins) with the pending bit staying 1.
REQ-017 SHALL implement FSM states IDLE, ISSUE, COMPLETE.
REQ-018 SHALL in IDLE with any pending bit set: select a winner, load mem_addr, clear the winner's pending bit, assert mem_req, go to ISSUE on the next edge.
REQ-019 SHALL hold mem_req=1 and mem_addr constant in ISSUE until mem_ack; on mem_ack capture mem_data into the winner's layer_data, drop mem_req, go to COMPLETE.
REQ-020 SHALL pulse layer_rdy[winner] for exactly the COMPLETE cycle, then return to IDLE.
REQ-021 SHALL, for a layer_req coinciding with its own grant, with ISSUE, or with COMPLETE for that layer, treat it as a new pending request; it SHALL NOT be lost or merged into the in-flight access.
REQ-022 SHALL ignore mem_ack outside ISSUE.
REQ-023 SHALL give best-case latency: layer_req at edge N, mem_req=1 after edge N+1, mem_ack at N+1+k, layer_rdy high the cycle after that ack.
REQ-024 SHALL use fixed priority by default: the lowest-index pending layer wins.

Reset
REQ-025 SHALL on reset=1 clear all pending bits and drive mem_req=0, mem_addr=0, layer_rdy=0, layer_data=0, busy=0, state=IDLE; round-robin pointer = NUM_LAYERS-1.
REQ-026 SHALL, on reset during ISSUE, abandon the access, drop mem_req next cycle, and produce no layer_rdy for it.

Configuration
REQ-027 SHALL, with GA23_ARB_ROUND_ROBIN_EN defined, grant the first pending layer at index > last-granted, wrapping modulo NUM_LAYERS; last-granted updates on each grant.
REQ-028 SHALL, without GA23_ARB_ROUND_ROBIN_EN, use the fixed priority of REQ-024 with no pointer register.

Structure
REQ-029 SHALL take the FSM state enum (IDLE/ISSUE/COMPLETE) and default ADDR_W/DATA_W constants from shared package ga23_pkg.
REQ-030 SHALL put winner selection in sub-module ga23_arb_pick: inputs pending vector and pointer, outputs one-hot grant and index; combinational only.

Verification
REQ-031 SHALL cover: layer 1 req addr 0x012340, mem_ack 3 cycles after mem_req -> mem_addr=0x012340; layer_rdy=3'b010 one cycle; layer_data[1]=mem_data 0xDEADBEEF.
REQ-032 SHALL cover: layers 0,1,2 req on the same cycle, fixed priority -> grant order 0,1,2, three rdy pulses, mem_req low ≥1 cycle between accesses.
REQ-033 SHALL cover: with GA23_ARB_ROUND_ROBIN_EN, layer 0 re-requests on every COMPLETE while layers 1,2 pending -> grant order 0,1,2,0,1,2.
REQ-034 SHALL cover: layer 2 reqs 0x000100 then 0x000200 before grant -> single access at 0x000200, one rdy pulse.
REQ-035 SHALL cover: layer 0 req during its own ISSUE with addr 0x000300 -> second access at 0x000300 after first completes, two rdy pulses.
REQ-036 SHALL cover: reset asserted in ISSUE, then stray mem_ack -> no layer_rdy, mem_req=0, busy=0, all pending cleared.

Source files
------------

// File: rtl/ga23_pkg.sv
// Shared types and default widths for the GA23 tile-layer SDRAM arbiter.
package ga23_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMPLETE
  } arb_state_e;

  localparam int unsigned GA23_ADDR_W = 22;
  localparam int unsigned GA23_DATA_W = 32;

endpackage

// File: rtl/ga23_arb_pick.sv
// Combinational winner picker: the first pending layer above ptr, wrapping to the lowest index.
// Driving ptr with NUM_LAYERS-1 turns this into plain lowest-index-wins priority.
module ga23_arb_pick #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [NUM_LAYERS-1:0] pending,
  input  logic [IDX_W-1:0]      ptr,
  output logic [NUM_LAYERS-1:0] grant,
  output logic [IDX_W-1:0]      index
);

  logic found;

  // Two ordered passes: indices above ptr first, then the wrapped indices.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && pending[i] && (i > 32'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && pending[i] && (i <= 32'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ga23_sdr_arbiter.sv
// Arbitrates per-layer tile-row reads onto one SDRAM read channel (IDLE -> ISSUE -> COMPLETE).
// Define GA23_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise the lowest pending index wins.
module ga23_sdr_arbiter
  import ga23_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned ADDR_W     = GA23_ADDR_W,
  parameter int unsigned DATA_W     = GA23_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LAYERS-1:0]        layer_req,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  output logic [NUM_LAYERS*DATA_W-1:0] layer_data,
  output logic [NUM_LAYERS-1:0]        layer_rdy,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         busy
);

  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  arb_state_e state_q, state_d;
  logic [NUM_LAYERS-1:0]             pending_q, pending_d;
  logic [NUM_LAYERS-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_LAYERS-1:0][DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]                 mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0]                  win_q, win_d;
  logic [NUM_LAYERS-1:0]             grant;
  logic [IDX_W-1:0]                  pick_idx;
  logic [IDX_W-1:0]                  ptr;

  ga23_arb_pick #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .pending (pending_q),
    .ptr     (ptr),
    .grant   (grant),
    .index   (pick_idx)
  );

`ifdef GA23_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |pending_q) ptr_d = pick_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= LAST_IDX;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = LAST_IDX;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    win_d      = win_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          win_d      = pick_idx;
          mem_addr_d = addr_q[pick_idx];
          pending_d  = pending_q & ~grant;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          data_d[win_q] = mem_data;
          state_d       = COMPLETE;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Applied after the grant clear so a request on the grant edge becomes a fresh pending one.
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_req[i]) begin
        pending_d[i] = 1'b1;
        addr_d[i]    = layer_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      win_q      <= win_d;
    end
  end

  assign mem_req    = (state_q == ISSUE);
  assign mem_addr   = mem_addr_q;
  assign busy       = (state_q != IDLE);
  assign layer_data = data_q;
  assign layer_rdy  = (state_q == COMPLETE) ? (NUM_LAYERS'(1) << win_q) : '0;

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Scoreboard bench for ga23_sdr_arbiter: expected grants queued at stimulus, retired on layer_rdy.
module tb_ga23_sdr_arbiter;

  localparam int unsigned NL = 3;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;

  typedef struct {
    int unsigned     layer;
    logic [AW-1:0]   addr;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NL-1:0]     layer_req;
  logic [NL*AW-1:0]  layer_addr;
  logic [NL*DW-1:0]  layer_data;
  logic [NL-1:0]     layer_rdy;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_ack;
  logic [DW-1:0]     mem_data;
  logic              busy;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   lat   = 2;
  int   stray_req  = 0;
  int   stray_done = 0;
  int   wait_cnt   = 0;
  logic ack_sent   = 1'b0;
  logic ack_edge   = 1'b0;

  ga23_sdr_arbiter #(
    .NUM_LAYERS (NL),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .layer_req  (layer_req),
    .layer_addr (layer_addr),
    .layer_data (layer_data),
    .layer_rdy  (layer_rdy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ack_edge <= mem_ack;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ {10'h0, a} ^ 32'h0001_2340;
  endfunction

  function automatic logic [NL*AW-1:0] one_addr(input int unsigned l, input logic [AW-1:0] a);
    logic [NL*AW-1:0] v;
    v = '0;
    v[l*AW +: AW] = a;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned l, input logic [AW-1:0] a);
    exp_t e;
    e.layer = l;
    e.addr  = a;
    sb.push_back(e);
  endtask

  task automatic req1(input int unsigned l, input logic [AW-1:0] a);
    @(negedge clk);
    layer_req  = NL'(1) << l;
    layer_addr = one_addr(l, a);
    @(negedge clk);
    layer_req  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("timeout_done", 1'b0, 1'b1);
  endtask

  task automatic wait_rdy(output int unsigned l);
    int n;
    n = 0;
    l = 0;
    do begin
      @(negedge clk);
      n++;
    end while (layer_rdy == '0 && n < 200);
    if (layer_rdy == '0) chk("timeout_rdy", 1'b0, 1'b1);
    for (int unsigned i = 0; i < NL; i++) if (layer_rdy[i]) l = i;
  endtask

  // Memory responder: acks lat cycles after mem_req rises; can also inject a stray ack.
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray_req != stray_done) begin
        mem_ack  = 1'b1;
        mem_data = 32'hBAD0BAD0;
        stray_done++;
      end else if (mem_req && !ack_sent) begin
        if (wait_cnt >= lat) begin
          mem_ack  = 1'b1;
          mem_data = mdata(mem_addr);
          ack_sent = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      if (!mem_req) begin
        wait_cnt = 0;
        ack_sent = 1'b0;
      end
    end
  end

  // Monitor: checks issue address, address stability and retires completions.
  initial begin
    logic                  prev_req;
    logic [AW-1:0]         issue_addr;
    logic [NL-1:0][DW-1:0] model;
    exp_t                  e;
    prev_req   = 1'b0;
    issue_addr = '0;
    model      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        model    = '0;
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          issue_addr = mem_addr;
          if (sb.size() > 0) chk("issue_addr", mem_addr, sb[0].addr);
        end
        if (mem_req) chk("addr_stable", mem_addr, issue_addr);
        prev_req = mem_req;
        if (layer_rdy != '0) begin
          if (sb.size() == 0) begin
            chk("rdy_unexpected", layer_rdy, '0);
          end else begin
            e = sb.pop_front();
            chk("rdy_onehot", layer_rdy, NL'(1) << e.layer);
            chk("rdy_after_ack", ack_edge, 1'b1);
            chk("req_low_complete", mem_req, 1'b0);
            chk("done_addr", issue_addr, e.addr);
            model[e.layer] = mdata(e.addr);
            chk("layer_data", layer_data, model);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned l;
    reset      = 1'b1;
    layer_req  = '0;
    layer_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_rdy", layer_rdy, '0);
    chk("rst_data", layer_data, '0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Single layer-1 access, ack three cycles after mem_req.
    lat = 2;
    push(1, 22'h012340);
    @(negedge clk);
    layer_req  = 3'b010;
    layer_addr = one_addr(1, 22'h012340);
    @(negedge clk);
    layer_req  = '0;
    chk("lat_req_early", mem_req, 1'b0);
    @(negedge clk);
    chk("lat_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 22'h012340);
    wait_done();
    chk("t1_data", layer_data[1*DW +: DW], 32'hDEADBEEF);

    // Three simultaneous requests: granted 0,1,2.
    do_reset();
    push(0, 22'h001000);
    push(1, 22'h002000);
    push(2, 22'h003000);
    @(negedge clk);
    layer_req  = 3'b111;
    layer_addr = {22'h003000, 22'h002000, 22'h001000};
    @(negedge clk);
    layer_req  = '0;
    wait_done();

    // Served layers re-request on their COMPLETE for the first three completions.
    do_reset();
    lat = 1;
`ifdef GA23_ARB_ROUND_ROBIN_EN
    push(0, 22'h000010); push(1, 22'h000020); push(2, 22'h000030);
    push(0, 22'h000401); push(1, 22'h000402); push(2, 22'h000403);
`else
    push(0, 22'h000010); push(0, 22'h000401); push(0, 22'h000402);
    push(0, 22'h000403); push(1, 22'h000020); push(2, 22'h000030);
`endif
    @(negedge clk);
    layer_req  = 3'b111;
    layer_addr = {22'h000030, 22'h000020, 22'h000010};
    @(negedge clk);
    layer_req  = '0;
    for (int unsigned c = 1; c <= 6; c++) begin
      wait_rdy(l);
      if (c <= 3) begin
        layer_req  = NL'(1) << l;
        layer_addr = one_addr(l, AW'(32'h400 + c));
        @(negedge clk);
        layer_req  = '0;
      end
    end
    wait_done();

    // Layer 2 requests twice while layer 0 is in flight: latest address wins.
    lat = 4;
    push(0, 22'h000050);
    push(2, 22'h000200);
    req1(0, 22'h000050);
    req1(2, 22'h000100);
    req1(2, 22'h000200);
    wait_done();

    // Layer 0 re-requests during its own ISSUE: a second access follows.
    lat = 3;
    push(0, 22'h000280);
    push(0, 22'h000300);
    req1(0, 22'h000280);
    req1(0, 22'h000300);
    wait_done();

    // Reset mid-ISSUE with another layer pending, then a stray ack.
    lat = 10;
    req1(1, 22'h000777);
    for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
    chk("t6_in_issue", mem_req, 1'b1);
    layer_req  = 3'b100;
    layer_addr = one_addr(2, 22'h000999);
    @(negedge clk);
    layer_req  = '0;
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    chk("t6_req_dropped", mem_req, 1'b0);
    chk("t6_busy", busy, 1'b0);
    stray_req++;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("t6_no_req", mem_req, 1'b0);
      chk("t6_no_rdy", layer_rdy, '0);
      chk("t6_idle", busy, 1'b0);
    end
    chk("t6_data_clear", layer_data, '0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
